debounce_edge_det: RTL and testbench
====================================

Name: debounce_edge_det

Overview:
- Conditioning stage that consumes a single-bit level, such as the Q output of the team's flip-flop cells or a raw pin.
- Synchronises the level into clk, then filters glitches shorter than DB_CYCLES clocks.
- Outputs a stable debounced level plus single-cycle rise and fall pulses for downstream control logic.
- Sits between the register/pin layer and any FSM that needs clean edge events.

Parameters:
- DB_CYCLES, 4: number of consecutive synchronised samples that must differ from dout before dout changes. Legal range is 1..255.
- RST_VAL, 1'b0: reset value of the synchroniser flops and dout.

Ports:
- clk  input  1  system clock; all logic on posedge.
- sync_rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
- din  input  1  raw level; may be asynchronous to clk.
- dout  output  1  debounced level, registered.
- rise  output  1  one-cycle pulse, registered; asserted in the cycle dout goes 0->1.
- fall  output  1  one-cycle pulse, registered; asserted in the cycle dout goes 1->0.
- busy  output  1  combinational from registers, equal to (s2 != dout); high while a change is being qualified.

Behaviour:
- Reset: when sync_rst_n==0 at a posedge:
  - s1, s2 and dout are set to RST_VAL.
  - cnt, rise and fall are set to 0.
  - busy therefore reads 0 after reset.
- Synchroniser: s1 <= din; s2 <= s1. Two flops, no reset bypass.
- Counter: cnt has width clog2(DB_CYCLES+1). Each posedge, when not in reset:
  - If s2 == dout: cnt <= 0, rise <= 0, fall <= 0.
  - Else if cnt == DB_CYCLES-1: dout <= s2, cnt <= 0, rise <= s2, fall <= ~s2.
  - Else: cnt <= cnt+1, rise <= 0, fall <= 0.
- Latency: call the first posedge that samples a new din level into s1 "edge 1". dout, and the matching pulse, change immediately after edge DB_CYCLES+2 (edge 6 at the default). Glitch-free input therefore has a fixed latency of DB_CYCLES+2 clocks.
- Glitch rejection: if s2 returns to dout before qualification completes, cnt clears to 0, dout does not change and no pulse is produced. A new change restarts counting from 0.
- Pulses:
  - rise and fall are never high together.
  - Each is high for exactly one clock per dout transition.
  - Consecutive opposite transitions are at least DB_CYCLES+1 clocks apart.
- DB_CYCLES==1: dout follows s2 one clock after the mismatch is seen, with no filtering beyond the synchroniser.
- Reset mid-qualification: the count is abandoned. dout returns to RST_VAL and no pulse is produced in or after the reset cycle. If din then differs from RST_VAL, a full qualification restarts after reset releases.
- Reset held: outputs stay at their reset values regardless of din.
- Counter never exceeds DB_CYCLES-1; there is no wrap.

Optional Feature:
- Macro: DB_RISE_CNT_EN.
- Defined:
  - Adds output rise_cnt [7:0].
  - Increments by 1 in every cycle rise is asserted; saturates at 255.
  - Reset to 0 by sync_rst_n.
  - Its update is registered in the same edge as rise, so rise_cnt reflects the new count in the same cycle rise is high.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Decomposition:
- Package db_pkg holds:
  - localparam DB_CYCLES_DEF = 4;
  - localparam DB_CNT_MAX = 255;
  - function db_cnt_w(n) returning clog2(n+1).
- Sub-module sync_2ff (params: RST_VAL) contains the s1/s2 chain with synchronous active-low reset. It is instantiated once, and is reusable by other input stages.

Test Plan (clk period 20 ns, DB_CYCLES=4, RST_VAL=0):
1. Reset: hold sync_rst_n=0 for 2 clocks with din=1 -> dout=0, rise=0, fall=0, busy=0 throughout. After release, dout=1 at edge 6 after release.
2. Clean rise: din 0->1 and held -> dout goes 1 after edge 6. rise=1 for exactly that one cycle. fall stays 0.
3. Glitch: din=1 for 3 clocks, then back to 0 -> busy pulses high, dout stays 0, no rise, cnt returns to 0.
4. Clean fall after a qualified rise: din 1->0 held -> dout 0 after edge 6, fall=1 for one cycle. rise and fall are never high together.
5. Reset mid-count: din 0->1, assert sync_rst_n=0 at edge 4 for one clock -> no rise pulse, dout=0. With din still 1, rise occurs 6 edges after release.
6. With DB_RISE_CNT_EN defined: 3 qualified rises -> rise_cnt=3. Force 260 rises -> rise_cnt holds 255.

Source files
------------

// File: rtl/db_pkg.sv
// Shared constants and helpers for the debounce/edge-detect input stage.
package db_pkg;

  localparam int DB_CYCLES_DEF = 4;
  localparam int DB_CNT_MAX    = 255;

  // Counter width able to hold 0..n
  function automatic int db_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchroniser with synchronous active-low reset.
// Reusable by any single-bit input stage.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic sync_rst_n,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/debounce_edge_det.sv
// Synchronise, debounce and edge-detect a single-bit level.
// Optional saturating rise counter enabled by defining DB_RISE_CNT_EN.
module debounce_edge_det
  import db_pkg::*;
#(
  parameter int   DB_CYCLES = DB_CYCLES_DEF,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic       clk,
  input  logic       sync_rst_n,
  input  logic       din,
  output logic       dout,
  output logic       rise,
  output logic       fall,
  output logic       busy
`ifdef DB_RISE_CNT_EN
  ,
  output logic [7:0] rise_cnt
`endif
);

  localparam int                CNT_W    = db_cnt_w(DB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s2;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sync_2ff #(
    .RST_VAL (RST_VAL)
  ) u_sync (
    .clk        (clk),
    .sync_rst_n (sync_rst_n),
    .d          (din),
    .q          (s2)
  );

  // A mismatch must persist for DB_CYCLES consecutive samples before dout follows
  always_comb begin
    dout_d = dout_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s2 != dout_q) begin
      if (cnt_q == CNT_LAST) begin
        dout_d = s2;
        rise_d = s2;
        fall_d = ~s2;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      dout_q <= RST_VAL;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (s2 != dout_q);

`ifdef DB_RISE_CNT_EN
  logic [7:0] rise_cnt_q, rise_cnt_d;

  // Keyed off rise_d so the count lands on the same edge as the pulse
  always_comb begin
    rise_cnt_d = rise_cnt_q;
    if (rise_d && (rise_cnt_q != 8'(DB_CNT_MAX)))
      rise_cnt_d = rise_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) rise_cnt_q <= 8'd0;
    else             rise_cnt_q <= rise_cnt_d;
  end

  assign rise_cnt = rise_cnt_q;
`endif

endmodule

// File: tb/tb_debounce_edge_det.sv
// Directed scoreboard bench for debounce_edge_det (DB_CYCLES=4, RST_VAL=0).
// Exercises the rise counter too when DB_RISE_CNT_EN is defined.
module tb_debounce_edge_det;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic sync_rst_n;
  logic din;
  logic dout, rise, fall, busy;
`ifdef DB_RISE_CNT_EN
  logic [7:0] rise_cnt;
  int         exp_rc = 0;
  int         rc_q[$];
`endif

  int total = 0;
  int bad   = 0;

  // Expected {dout, rise, fall, busy} per clock
  logic [3:0] exp_q[$];

  always #10 clk = ~clk;

  debounce_edge_det #(
    .DB_CYCLES (DB),
    .RST_VAL   (1'b0)
  ) dut (
    .clk        (clk),
    .sync_rst_n (sync_rst_n),
    .din        (din),
    .dout       (dout),
    .rise       (rise),
    .fall       (fall),
    .busy       (busy)
`ifdef DB_RISE_CNT_EN
    ,
    .rise_cnt   (rise_cnt)
`endif
  );

  task automatic tick(input logic d, input logic r, input logic [3:0] e, input string tag);
    logic [3:0] exp_v;
    logic [3:0] obs_v;
    din        = d;
    sync_rst_n = r;
    exp_q.push_back(e);
`ifdef DB_RISE_CNT_EN
    if (!r) exp_rc = 0;
    else if (e[2] && exp_rc < 255) exp_rc++;
    rc_q.push_back(exp_rc);
`endif
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    obs_v = {dout, rise, fall, busy};
    total++;
    assert (obs_v === exp_v) else begin
      bad++;
      $error("FAIL %s {dout,rise,fall,busy} got=%b want=%b", tag, obs_v, exp_v);
    end
`ifdef DB_RISE_CNT_EN
    begin
      int exp_c;
      exp_c = rc_q.pop_front();
      total++;
      assert (rise_cnt === 8'(exp_c)) else begin
        bad++;
        $error("FAIL %s_rise_cnt got=%0d want=%0d", tag, rise_cnt, exp_c);
      end
    end
`endif
  endtask

  // Drive a clean level change from ~nv to nv and hold it; dout flips after edge DB+2
  task automatic qualify(input logic nv, input string tag);
    logic ed, er, ef, eb;
    for (int k = 1; k <= DB + 3; k++) begin
      ed = (k >= DB + 2) ? nv : ~nv;
      er = (k == DB + 2) && nv;
      ef = (k == DB + 2) && !nv;
      eb = (k >= 2) && (k <= DB + 1);
      tick(nv, 1'b1, {ed, er, ef, eb}, tag);
    end
  endtask

  initial begin
    din        = 1'b1;
    sync_rst_n = 1'b0;
    #5;

    // Reset held two clocks with din high
    tick(1'b1, 1'b0, 4'b0000, "rst_hold0");
    tick(1'b1, 1'b0, 4'b0000, "rst_hold1");
    qualify(1'b1, "rst_release_rise");

    // Clean fall, rise, fall
    qualify(1'b0, "clean_fall");
    qualify(1'b1, "clean_rise");
    qualify(1'b0, "clean_fall2");

    // Glitch of DB-1 clocks: busy pulses, dout never moves
    tick(1'b1, 1'b1, 4'b0000, "glitch1");
    tick(1'b1, 1'b1, 4'b0001, "glitch2");
    tick(1'b1, 1'b1, 4'b0001, "glitch3");
    tick(1'b0, 1'b1, 4'b0001, "glitch4");
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 4'b0000, "glitch_settle");
    // A fresh change after the glitch still needs the full qualification
    qualify(1'b1, "post_glitch_rise");
    qualify(1'b0, "post_glitch_fall");

    // Reset on edge 4 of a qualification abandons it
    tick(1'b1, 1'b1, 4'b0000, "midrst1");
    tick(1'b1, 1'b1, 4'b0001, "midrst2");
    tick(1'b1, 1'b1, 4'b0001, "midrst3");
    tick(1'b1, 1'b0, 4'b0000, "midrst_reset");
    qualify(1'b1, "midrst_requalify");

    // Reset while dout=1 with din toggling: no fall pulse, outputs pinned
    tick(1'b0, 1'b0, 4'b0000, "rst_toggle0");
    tick(1'b1, 1'b0, 4'b0000, "rst_toggle1");
    tick(1'b0, 1'b0, 4'b0000, "rst_toggle2");
    tick(1'b1, 1'b0, 4'b0000, "rst_toggle3");
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 4'b0000, "rst_quiet");

`ifdef DB_RISE_CNT_EN
    tick(1'b0, 1'b0, 4'b0000, "rc_reset");
    for (int i = 0; i < 3; i++) begin
      qualify(1'b1, "rc_rise");
      qualify(1'b0, "rc_fall");
    end
    total++;
    assert (rise_cnt === 8'd3) else begin
      bad++;
      $error("FAIL rc_three got=%0d want=3", rise_cnt);
    end
    for (int i = 0; i < 257; i++) begin
      qualify(1'b1, "rc_sat_rise");
      qualify(1'b0, "rc_sat_fall");
    end
    total++;
    assert (rise_cnt === 8'd255) else begin
      bad++;
      $error("FAIL rc_saturate got=%0d want=255", rise_cnt);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
